// File: rtl/lfsr_prbs_chk_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair (package lfsr_pkg).
// Holds the default width/taps, the checker state encoding and the feedback helper.
package lfsr_pkg;

   localparam int          LFSR_W_DEF  = 48;
   localparam logic [47:0] TAPS_DEF    = 48'hC000_0018_0000;
   // Widest LFSR the feedback helper accepts; callers zero-extend narrower states.
   localparam int          LFSR_MAX_W  = 64;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_chk_state_t;

   function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] state,
                                    input logic [LFSR_MAX_W-1:0] taps);
      return ^(state & taps);
   endfunction

endpackage

// File: rtl/lfsr_prbs_chk_if.sv
// Bus between a PRBS source and the lfsr_prbs_chk checker.
// The bit_count signal exists only when LFSR_PRBS_CHK_BITCNT_EN is defined.
interface lfsr_prbs_chk_if #(
   parameter int CNT_W = 32
);
   import lfsr_pkg::*;

   // enable qualifies data_in for exactly one cycle; the checker never
   // back-pressures, so every enabled cycle is consumed on that clock edge.
   logic             enable;
   logic             data_in;
   logic             clr_cnt;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
`ifdef LFSR_PRBS_CHK_BITCNT_EN
   logic [CNT_W-1:0] bit_count;
`endif
   prbs_chk_state_t  dbg_state;

`ifdef LFSR_PRBS_CHK_BITCNT_EN
   modport master (
      output enable, data_in, clr_cnt,
      input  locked, err_pulse, err_count, bit_count, dbg_state
   );
   modport slave (
      input  enable, data_in, clr_cnt,
      output locked, err_pulse, err_count, bit_count, dbg_state
   );
`else
   modport master (
      output enable, data_in, clr_cnt,
      input  locked, err_pulse, err_count, dbg_state
   );
   modport slave (
      input  enable, data_in, clr_cnt,
      output locked, err_pulse, err_count, dbg_state
   );
`endif

endinterface

// File: rtl/lfsr_prbs_chk_sat_counter.sv
// Saturating up-counter with synchronous clear (module sat_counter).
// Clear has priority over increment, so a coincident event reads back as zero.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/lfsr_prbs_chk.sv
// PRBS checker: self-seeds from the received stream, verifies, then tracks
// lock/loss-of-lock and counts errors. Optional bit counter: LFSR_PRBS_CHK_BITCNT_EN.
module lfsr_prbs_chk
   import lfsr_pkg::*;
#(
   parameter int                LFSR_W      = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] TAPS        = LFSR_W'(TAPS_DEF),
   parameter int                CNT_W       = 32,
   parameter int                LOSS_WIN    = 64,
   parameter int                LOSS_THRESH = 8
) (
   input  logic            clk,
   input  logic            rst,
   lfsr_prbs_chk_if.slave  bus
);

   localparam int PH_W   = $clog2(LFSR_W);
   localparam int WIN_W  = $clog2(LOSS_WIN);
   localparam int WERR_W = $clog2(LOSS_THRESH + 1);

   prbs_chk_state_t   st_q, st_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [PH_W-1:0]   seed_cnt_q, seed_cnt_d;
   logic [PH_W-1:0]   ver_cnt_q, ver_cnt_d;
   logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
   logic [WERR_W-1:0] win_err_q, win_err_d;
   logic [WERR_W-1:0] werr_sum;
   logic              err_pulse_q;
   logic              err_now;
   logic              pred;
   logic              mismatch;
   logic [CNT_W-1:0]  err_count;

   assign pred     = lfsr_fb(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS));
   assign mismatch = bus.data_in ^ pred;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= SEED;
         lfsr_q      <= '0;
         seed_cnt_q  <= '0;
         ver_cnt_q   <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         lfsr_q      <= lfsr_d;
         seed_cnt_q  <= seed_cnt_d;
         ver_cnt_q   <= ver_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         err_pulse_q <= err_now;
      end
   end

   always_comb begin
      st_d       = st_q;
      lfsr_d     = lfsr_q;
      seed_cnt_d = seed_cnt_q;
      ver_cnt_d  = ver_cnt_q;
      win_cnt_d  = win_cnt_q;
      win_err_d  = win_err_q;
      werr_sum   = win_err_q;
      err_now    = 1'b0;

      if (bus.enable) begin
         case (st_q)
            SEED: begin
               lfsr_d = {lfsr_q[LFSR_W-2:0], bus.data_in};
               if (seed_cnt_q == PH_W'(LFSR_W - 1)) begin
                  st_d       = VERIFY;
                  seed_cnt_d = '0;
                  ver_cnt_d  = '0;
               end else begin
                  seed_cnt_d = seed_cnt_q + PH_W'(1);
               end
            end

            VERIFY: begin
               // An all-zero state predicts zeros forever, so a dead line would lock.
               if (mismatch || (lfsr_q == '0)) begin
                  st_d       = SEED;
                  lfsr_d     = '0;
                  seed_cnt_d = '0;
                  ver_cnt_d  = '0;
               end else begin
                  lfsr_d = {lfsr_q[LFSR_W-2:0], pred};
                  if (ver_cnt_q == PH_W'(LFSR_W - 1)) begin
                     st_d      = LOCKED;
                     ver_cnt_d = '0;
                     win_cnt_d = '0;
                     win_err_d = '0;
                  end else begin
                     ver_cnt_d = ver_cnt_q + PH_W'(1);
                  end
               end
            end

            LOCKED: begin
               // Free-running on the prediction so a bad bit cannot corrupt the state.
               lfsr_d   = {lfsr_q[LFSR_W-2:0], pred};
               err_now  = mismatch;
               werr_sum = win_err_q + {{(WERR_W-1){1'b0}}, mismatch};
               if (werr_sum >= WERR_W'(LOSS_THRESH)) begin
                  st_d       = SEED;
                  lfsr_d     = '0;
                  seed_cnt_d = '0;
                  win_cnt_d  = '0;
                  win_err_d  = '0;
               end else if (win_cnt_q == WIN_W'(LOSS_WIN - 1)) begin
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  win_cnt_d = win_cnt_q + WIN_W'(1);
                  win_err_d = werr_sum;
               end
            end

            default: begin
               st_d       = SEED;
               lfsr_d     = '0;
               seed_cnt_d = '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clr_cnt),
      .inc   (err_now),
      .count (err_count)
   );

`ifdef LFSR_PRBS_CHK_BITCNT_EN
   logic             bit_inc;
   logic [CNT_W-1:0] bit_count;

   assign bit_inc = bus.enable && (st_q == LOCKED);

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clr_cnt),
      .inc   (bit_inc),
      .count (bit_count)
   );

   assign bus.bit_count = bit_count;
`endif

   assign bus.locked    = (st_q == LOCKED);
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_count = err_count;
   assign bus.dbg_state = st_q;

endmodule
